serial_subtractor_16bit: RTL
============================

Name: serial_subtractor_16bit

Overview:
- Bit-serial two's-complement subtractor for the PID datapath: computes minuend - subtrahend - bin, one bit per clock, LSB first.
- Produces the controller error term (setpoint - feedback) and the borrow/overflow flags.
- Uses far less area than the parallel 16-bit ripple adder.
- Sits between the setpoint/feedback registers and the P/I/D term blocks.
- Optional signed saturation so downstream gain stages never see a wrapped error.

Parameters:
- WIDTH, 16, operand and result width in bits; also the bit-cycle count.
- SATURATE, 0, 1 = clamp `diff` to 0x7FFF/0x8000 on signed overflow; 0 = wrap.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when idle.
- minuend  input  WIDTH  operand A (e.g. setpoint), captured on accepted start.
- subtrahend  input  WIDTH  operand B (e.g. feedback), captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result valid and updated.
- diff  output  WIDTH  result, held until the next done.
- bout  output  1  borrow-out (unsigned A < B + bin), held with diff.
- ovf  output  1  signed overflow of the unsaturated result, held with diff.

Behaviour:
- Reset: one clock; synchronous, active-high. On rst, at the clock edge: state <= IDLE; busy, done, diff, bout, ovf <= 0; shift registers, bit counter and borrow flop <= 0.
- Reset mid-operation aborts the operation: no done pulse is produced and no partial result is exposed.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at an edge: latch minuend, subtrahend and bin; counter <= 0; state <= RUN; busy <= 1.
  - Otherwise hold.
- RUN, each edge:
  - a0 = A[0], b0 = B[0], br = borrow flop.
  - d = a0^b0^br.
  - br_next = (~a0&b0) | (~(a0^b0)&br).
  - Shift A and B right; shift d into result MSB.
  - counter++.
  - The borrow flop is seeded from bin at capture.
- Completion: on the edge that processes bit WIDTH-1:
  - diff <= final result (saturated if applicable); bout <= br_next; ovf computed.
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: start high in cycle 0 gives busy high in cycles 1..15 and done high in cycle 16. Throughput is one result per 16 cycles.
- Back-to-back: start asserted in the done cycle is accepted; the next done follows 16 cycles later.
- start while busy=1 is ignored. Operands changing during RUN have no effect.
- Overflow: ovf = (A15 != B15) && (raw15 != A15), using captured operands and the raw result.
- Saturation, SATURATE=1 and ovf=1: diff = 0x7FFF if A15=0, else 0x8000.
- bout always reflects the unsigned borrow regardless of SATURATE.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package pid_pkg:
  - state enum {IDLE, RUN}.
  - DATA_W = 16.
  - SAT_MAX = 16'h7FFF, SAT_MIN = 16'h8000.
  - Counter width $clog2(DATA_W).
- One sub-module, full_subtractor: a single-bit combinational cell (in_1, in_2, br_in -> diff, br_out). It is the bit-slice counterpart of the existing adder cell.
- Control FSM, shift registers and flag logic stay in the top module.

Test Plan:
- 0x1234 - 0x0034, bin=0, start in cycle 0 -> done only in cycle 16; diff=0x1200, bout=0, ovf=0; busy high in cycles 1..15.
- 0x0000 - 0x0001 -> diff=0xFFFF, bout=1, ovf=0. Then 0x0005 - 0x0003 with bin=1 -> diff=0x0001, bout=0.
- SATURATE=0: 0x8000 - 0x0001 -> diff=0x7FFF, ovf=1. SATURATE=1, same operands -> diff=0x8000, ovf=1. SATURATE=1: 0x7FFF - 0xFFFF -> diff=0x7FFF, ovf=1, bout=1.
- start pulsed again at cycle 5 with new operands during an operation -> ignored; first result unchanged at cycle 16; no extra done.
- rst asserted in cycle 8 mid-operation -> next cycle busy=0, diff=0, no done. A fresh start then completes normally 16 cycles later.
- Back-to-back: second start held high in the done cycle -> second done exactly 16 cycles after the first, with the correct second result.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types and constants for the PID datapath blocks.
package pid_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_subtractor_16bit_full_subtractor.sv
// Single-bit subtract cell: in_1 - in_2 - br_in, bit-slice counterpart of the adder cell.
module full_subtractor (
  input  logic in_1,
  input  logic in_2,
  input  logic br_in,
  output logic diff,
  output logic br_out
);

  assign diff   = in_1 ^ in_2 ^ br_in;
  assign br_out = (~in_1 & in_2) | (~(in_1 ^ in_2) & br_in);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial two's-complement subtractor, LSB first, with borrow/overflow flags
// and optional signed saturation of the result.
module serial_subtractor_16bit
  import pid_pkg::*;
#(
  parameter int unsigned WIDTH    = DATA_W,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned     SER_CNT_W = $clog2(WIDTH);
  localparam logic [SER_CNT_W-1:0] LAST_RUN = SER_CNT_W'(WIDTH - 2);
  localparam logic [WIDTH-1:0] SAT_HI   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_LO   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic                   br_q, br_d;
  logic [SER_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   busy_d, done_d, bout_d, ovf_d;
  logic [WIDTH-1:0]       diff_d;

  logic                   fs_a, fs_b, fs_br, fs_d, fs_bo;
  logic [WIDTH-1:0]       raw;
  logic                   ovf_w;

  // The capture edge already processes bit 0 straight from the operand inputs,
  // so the remaining WIDTH-1 bits fit in the busy window.
  assign fs_a  = (state_q == IDLE) ? minuend[0]    : a_q[0];
  assign fs_b  = (state_q == IDLE) ? subtrahend[0] : b_q[0];
  assign fs_br = (state_q == IDLE) ? bin           : br_q;

  full_subtractor u_fs (
    .in_1  (fs_a),
    .in_2  (fs_b),
    .br_in (fs_br),
    .diff  (fs_d),
    .br_out(fs_bo)
  );

  // On the last bit fs_a/fs_b are the operand sign bits and fs_d the raw sign.
  assign raw   = {fs_d, res_q[WIDTH-1:1]};
  assign ovf_w = (fs_a != fs_b) && (fs_d != fs_a);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      diff    <= diff_d;
      bout    <= bout_d;
      ovf     <= ovf_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_d  = 1'b0;
    diff_d  = diff;
    bout_d  = bout;
    ovf_d   = ovf;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = minuend >> 1;
          b_d     = subtrahend >> 1;
          res_d   = {fs_d, {(WIDTH-1){1'b0}}};
          br_d    = fs_bo;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = raw;
        br_d  = fs_bo;
        cnt_d = cnt_q + SER_CNT_W'(1);
        if (cnt_q == LAST_RUN) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          br_d    = 1'b0;
          bout_d  = fs_bo;
          ovf_d   = ovf_w;
          diff_d  = (SATURATE && ovf_w) ? (fs_a ? SAT_LO : SAT_HI) : raw;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
